uart_img_loader: RTL
====================

// Module: uart_img_loader
// PURPOSE
//  Sits inside SNN directly downstream of uart_rx. Collects one 784-pixel binary image
//  (98 bytes, 8 pixels/byte) from the UART byte stream and unpacks it bit-serially
//  into the 784x1 input-sample RAM. It then hands the image to the SNN core with a
//  valid/ack handshake. It also resynchronises the frame after an inter-byte timeout.
// PARAMETERS
//  NUM_BYTES  98         bytes per image (784/8)
//  ADDR_W     10         RAM address width (covers 0..783)
//  TIMEOUT    1_000_000  idle clk cycles mid-frame before the frame is discarded
// PORTS
//  clk        in   1       system clock
//  rst_n      in   1       asynchronous, active-low reset
//  rx_rdy     in   1       1-cycle strobe from uart_rx: rx_data valid
//  rx_data    in   8       received byte
//  ram_we     out  1       write strobe to input RAM
//  ram_addr   out  ADDR_W  pixel address, 0..783
//  ram_wdata  out  1       pixel bit
//  img_valid  out  1       image complete in RAM; level, held until img_ack
//  img_ack    in   1       1-cycle strobe from SNN core: image consumed
//  busy       out  1       frame in progress (state != IDLE or bytes received > 0)
//  ovf_err    out  1       sticky: byte lost (holding reg full, or arrived in DONE)
// BEHAVIOUR
//  Reset: all outputs 0; byte counter 0; holding register empty; state IDLE.
//  States: IDLE, UNPACK, DONE.
//  Holding register: 1-deep, 8-bit, plus a full flag.
//   - rx_rdy sets it in any state except DONE.
//   - If rx_rdy arrives while it is already full, the new byte is dropped and ovf_err=1.
//  IDLE: if holding full -> UNPACK, byte moved to shift reg, holding emptied same cycle.
//  UNPACK: 8 cycles, one pixel/cycle; bit order is LSB first.
//   - ram_we=1, ram_addr=byte_idx*8+k, ram_wdata=byte[k], k=0..7.
//   - Outputs are registered; the first write is 1 cycle after leaving IDLE.
//   - After k=7, byte_idx increments.
//   - If byte_idx reaches NUM_BYTES: -> DONE, byte_idx := 0.
//   - Else if holding full: reload the shift reg back-to-back and stay in UNPACK.
//   - Else: -> IDLE.
//  DONE: img_valid=1 and no RAM writes.
//   - rx_rdy in DONE: byte discarded, ovf_err=1.
//   - img_ack: img_valid=0 the next cycle, ovf_err cleared, -> IDLE.
//   - img_ack in any other state is ignored.
//  Timeout: a counter runs while in IDLE with 0 < byte_idx < NUM_BYTES; it clears on
//   every rx_rdy. When it reaches TIMEOUT-1: byte_idx := 0, partial frame abandoned.
//   RAM is not cleared; ovf_err is unchanged.
//  Simultaneous events: rx_rdy in the same cycle the holding reg is drained -> the new
//   byte is accepted, no overflow. rx_rdy together with img_ack in DONE -> the byte is
//   dropped (ovf_err set, then cleared by the ack: the ack wins).
//  Reset mid-operation: immediate return to reset values; partial RAM contents stay.
//  Width: byte_idx is 7 bits; ram_addr = {byte_idx,3'b0}+k, max 783 < 2^ADDR_W.
// STRUCTURE
//  snn_pkg: NUM_PIXELS=784, NUM_BYTES=98, ADDR_W=10, typedef enum {IDLE,UNPACK,DONE}
//   ldr_state_t (shared with the core's handshake checker).
//  Sub-module byte_unpacker: shift reg + 3-bit bit counter, load/done handshake.
//  FSM, holding register and timeout counter stay in uart_img_loader.
// TESTING
//  1) Send 98 bytes, byte 0=8'hA5, rest 8'h00 -> writes to addr 0..7 = 1,0,1,0,0,1,0,1;
//     784 writes total; img_valid rises 1 cycle after addr 783 is written.
//  2) Two rx_rdy 2 cycles apart (8'hFF, 8'h01) -> addr 0..7 all 1, addr 8=1,
//     9..15=0; writes contiguous (16 consecutive we cycles); ovf_err=0.
//  3) Three rx_rdy on consecutive cycles during UNPACK -> third byte dropped, ovf_err=1.
//  4) Full image, no ack, then extra byte 8'h55 -> no ram_we, ovf_err=1. Pulse img_ack
//     -> img_valid=0, ovf_err=0, busy=0; a new 98-byte frame writes again from addr 0.
//  5) 40 bytes, then idle TIMEOUT cycles (TIMEOUT=100 in bench), then 98 bytes ->
//     writes restart at addr 0; img_valid only after the second frame.
//  6) Assert rst_n=0 mid-UNPACK at addr 13 -> ram_we/img_valid/busy/ovf_err 0 the
//     same cycle; the next byte writes addr 0..7.

Source files
------------

// File: rtl/uart_img_loader_pkg.sv
// Shared definitions for the SNN image loader.
// Contents:
//   NUM_PIXELS / NUM_BYTES / ADDR_W : image geometry and input-RAM address width
//   ldr_state_t                     : loader FSM states, also used by the core's
//                                     handshake checker
//   pixel_addr()                    : RAM address of pixel k of byte byte_idx
package uart_img_loader_pkg;

  localparam int NUM_PIXELS = 784;
  localparam int NUM_BYTES  = 98;
  localparam int ADDR_W     = 10;

  typedef enum logic [1:0] {
    IDLE,
    UNPACK,
    DONE
  } ldr_state_t;

  // Eight pixels per byte, so the byte index forms the upper address bits.
  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [6:0] byte_idx,
                                                   input logic [2:0] bit_idx);
    return {byte_idx, 3'b000} + ADDR_W'(bit_idx);
  endfunction

endpackage

// File: rtl/uart_img_loader_if.sv
// Signal bundle between uart_rx, the image loader, the input RAM and the SNN core.
// Signals:
//   rx_rdy, rx_data          : byte strobe and byte from uart_rx
//   ram_we, ram_addr, ram_wdata : bit-serial write port of the 784x1 input RAM
//   img_valid, img_ack       : image-ready level and consume strobe to/from the core
//   busy, ovf_err            : status (frame in progress, sticky byte-lost flag)
// Modports:
//   master : the loader side (drives the RAM port and status)
//   slave  : the environment side (uart_rx, RAM, core)
interface uart_img_loader_if;
  import uart_img_loader_pkg::*;

  logic              rx_rdy;
  logic [7:0]        rx_data;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wdata;
  logic              img_valid;
  logic              img_ack;
  logic              busy;
  logic              ovf_err;

  modport master (
    input  rx_rdy, rx_data, img_ack,
    output ram_we, ram_addr, ram_wdata, img_valid, busy, ovf_err
  );

  modport slave (
    output rx_rdy, rx_data, img_ack,
    input  ram_we, ram_addr, ram_wdata, img_valid, busy, ovf_err
  );

endinterface

// File: rtl/uart_img_loader_byte_unpacker.sv
// Serialises one byte into eight pixels, LSB first, one pixel per clock.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load, din  : load a new byte (restarts the bit counter; allowed on the last bit)
//   active     : a byte is being serialised
//   bit_out    : current pixel value
//   bit_idx    : current pixel index k within the byte
//   last       : current pixel is k=7
module uart_img_loader_byte_unpacker (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] din,
  output logic       active,
  output logic       bit_out,
  output logic       last,
  output logic [2:0] bit_idx
);

  logic [7:0] shift_q;

  // Load has priority so a byte can follow the previous one without a gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      bit_idx <= '0;
      active  <= 1'b0;
    end else if (load) begin
      shift_q <= din;
      bit_idx <= 3'd0;
      active  <= 1'b1;
    end else if (active) begin
      shift_q <= {1'b0, shift_q[7:1]};
      bit_idx <= bit_idx + 3'd1;
      if (bit_idx == 3'd7) active <= 1'b0;
    end
  end

  assign bit_out = shift_q[0];
  assign last    = active && (bit_idx == 3'd7);

endmodule

// File: rtl/uart_img_loader.sv
// Collects a 98-byte packed binary image from the UART byte stream, unpacks it
// bit-serially into the 784x1 input RAM and offers it to the SNN core with a
// valid/ack handshake. A long gap mid-frame abandons the partial frame.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : uart_img_loader_if.master (byte input, RAM write port,
//                img_valid/img_ack handshake, busy and ovf_err status)
// Parameters:
//   TIMEOUT    : idle cycles mid-frame before the partial frame is discarded
module uart_img_loader
  import uart_img_loader_pkg::*;
#(
  parameter int TIMEOUT = 1_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_img_loader_if.master   bus
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  ldr_state_t       state, next_state;
  logic [6:0]       byte_idx;
  logic [7:0]       hold_data;
  logic             hold_full;
  logic [CNT_W-1:0] idle_cnt;
  logic             load;
  logic             frame_end;
  logic             tmo_run;
  logic             timeout_hit;
  logic             ub_active;
  logic             ub_bit;
  logic             ub_last;
  logic [2:0]       ub_idx;

  uart_img_loader_byte_unpacker u_unpacker (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .din     (hold_data),
    .active  (ub_active),
    .bit_out (ub_bit),
    .last    (ub_last),
    .bit_idx (ub_idx)
  );

  assign frame_end   = ub_last && (byte_idx == 7'(NUM_BYTES - 1));
  assign tmo_run     = (state == IDLE) && (byte_idx != 7'd0);
  assign timeout_hit = tmo_run && !bus.rx_rdy && (idle_cnt == CNT_W'(TIMEOUT - 1));

  // Next state; load also marks the cycle the holding register is drained.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) begin
          next_state = UNPACK;
          load       = 1'b1;
        end
      end
      UNPACK: begin
        if (ub_last) begin
          if (frame_end)      next_state = DONE;
          else if (hold_full) load       = 1'b1;
          else                next_state = IDLE;
        end
      end
      DONE: begin
        if (bus.img_ack) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Byte position in the frame: advances after the eighth pixel, wraps at the
  // end of the image, and is cleared when a partial frame times out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx <= '0;
    end else if (ub_last) begin
      byte_idx <= frame_end ? 7'd0 : byte_idx + 7'd1;
    end else if (timeout_hit) begin
      byte_idx <= '0;
    end
  end

  // One-deep holding register. A byte arriving on the drain cycle is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data <= '0;
      hold_full <= 1'b0;
    end else if (bus.rx_rdy && (state != DONE) && (!hold_full || load)) begin
      hold_data <= bus.rx_data;
      hold_full <= 1'b1;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  // Sticky overflow; the ack clears it even if a byte is dropped the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ovf_err <= 1'b0;
    end else if ((state == DONE) && bus.img_ack) begin
      bus.ovf_err <= 1'b0;
    end else if (bus.rx_rdy && ((state == DONE) || (hold_full && !load))) begin
      bus.ovf_err <= 1'b1;
    end
  end

  // Idle-gap counter, only meaningful while a partial frame sits in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (bus.rx_rdy || !tmo_run || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + CNT_W'(1);
    end
  end

  // Registered RAM port and image-ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= 1'b0;
      bus.img_valid <= 1'b0;
    end else begin
      bus.ram_we    <= ub_active;
      bus.ram_addr  <= ub_active ? pixel_addr(byte_idx, ub_idx) : '0;
      bus.ram_wdata <= ub_active && ub_bit;
      bus.img_valid <= (state == DONE) && !bus.img_ack;
    end
  end

  assign bus.busy = (state != IDLE) || (byte_idx != 7'd0);

endmodule
